ofdm_frame_scheduler: RTL and testbench

Runtime-configurable successor to the frame synchronizer: consumes the Minn detector AXI4-Stream, locks to the first start-of-frame (SOF) flag, strips cyclic prefixes and the inter-frame gap, and emits payload samples tagged with their symbol index towards the FFT. Frame geometry (NFFT, CP length, symbols per frame, gap) is a register input, not a parameter. Real input back-pressure replaces overflow errors. Signed sample-time offset (STO) corrections are accumulated across the whole tracking window.

---
 rtl/ofdm_frame_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_ofdm_frame_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_frame_scheduler.sv
// OFDM frame scheduler: locks to SOF, strips CP and inter-frame gap, tags payload with symbol index.
// Optional build macro OFDM_FRAME_SCHED_RESYNC_EN: an SOF seen during the gap restarts the frame on that beat.
module ofdm_frame_scheduler #(
  parameter int INPUT_WIDTH          = 12,
  parameter int NFFT_MAX             = 4096,
  parameter int CP_MAX               = 1024,
  parameter int SYMBOL_COUNTER_WIDTH = 7,
  parameter int GAP_WIDTH            = 20,
  parameter int FIFO_DEPTH           = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [4*INPUT_WIDTH-1:0]          s_axis_tdata,
  input  logic                              s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  output logic [4*INPUT_WIDTH-1:0]          m_axis_tdata,
  output logic [SYMBOL_COUNTER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic [$clog2(NFFT_MAX+1)-1:0]     cfg_nfft,
  input  logic [$clog2(CP_MAX+1)-1:0]       cfg_cp_len,
  input  logic [SYMBOL_COUNTER_WIDTH-1:0]   cfg_n_symbols,
  input  logic [GAP_WIDTH-1:0]              cfg_gap,
  input  logic                              cfg_last_per_symbol,
  input  logic                              soft_resync,
  input  logic signed [7:0]                 sto_correction,
  input  logic                              sto_valid,
  output logic                              sto_ready,
  output logic                              locked,
  output logic [15:0]                       frame_count
);

  localparam int SW  = $clog2(NFFT_MAX + CP_MAX);
  localparam int NW  = $clog2(NFFT_MAX + 1);
  localparam int CW  = $clog2(CP_MAX + 1);
  localparam int LW  = SW + 1;
  localparam int SCW = SYMBOL_COUNTER_WIDTH;
  localparam int DW  = 4 * INPUT_WIDTH;
  localparam int EW  = DW + SCW + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = GAP_WIDTH + 1;
  localparam int XW  = GAP_WIDTH + 3;

  localparam logic signed [PW:0]   PEND_MAX = (PW+1)'((1 << (PW-1)) - 1);
  localparam logic signed [PW:0]   PEND_MIN = ~PEND_MAX;
  localparam logic signed [PW-1:0] PEND_ONE = PW'(1);

  localparam logic [1:0] ST_SEARCHING  = 2'd0;
  localparam logic [1:0] ST_COLLECTING = 2'd1;
  localparam logic [1:0] ST_TRACKING   = 2'd2;

`ifdef OFDM_FRAME_SCHED_RESYNC_EN
  localparam logic RESYNC_EN = 1'b1;
`else
  localparam logic RESYNC_EN = 1'b0;
`endif

  logic [1:0]            state_reg;
  logic [SW-1:0]         sample_reg;
  logic [SCW-1:0]        sym_reg;
  logic [GAP_WIDTH-1:0]  gap_reg;
  logic signed [PW-1:0]  pending_reg;
  logic                  locked_reg;
  logic [15:0]           frame_count_reg;
  logic [NW-1:0]         nfft_sh;
  logic [CW-1:0]         cp_sh;
  logic [SCW-1:0]        nsym_sh;
  logic [GAP_WIDTH-1:0]  gap_sh;
  logic                  lps_sh;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]           count_reg, count_next;
  logic                  tready_reg;

  logic in_fire, sto_fire, push, pop, start, in_frame, eff_zero;
  logic signed [PW:0]   pend_sum;
  logic signed [PW-1:0] pend_sat;
  logic signed [XW-1:0] eff_sum;

  logic [NW-1:0]        cur_nfft;
  logic [CW-1:0]        cur_cp;
  logic [SCW-1:0]       cur_nsym, cur_sym;
  logic [GAP_WIDTH-1:0] cur_gap;
  logic                 cur_lps;
  logic [SW-1:0]        cur_sample;
  logic                 is_payload, end_sym, end_frame, push_last;

  assign in_fire   = s_axis_tvalid && s_axis_tready;
  assign sto_ready = (state_reg == ST_TRACKING);
  assign sto_fire  = sto_valid && sto_ready;

  // Pending STO accumulator and effective gap, both including a same-cycle accept.
  always_comb begin
    pend_sum = {pending_reg[PW-1], pending_reg};
    if (sto_fire)
      pend_sum = pend_sum + (PW+1)'(sto_correction);
    if (pend_sum > PEND_MAX)
      pend_sat = PEND_MAX[PW-1:0];
    else if (pend_sum < PEND_MIN)
      pend_sat = PEND_MIN[PW-1:0];
    else
      pend_sat = pend_sum[PW-1:0];
    eff_sum  = $signed({3'b000, gap_reg}) + XW'(pend_sat);
    eff_zero = eff_sum[XW-1] || (eff_sum == '0);
  end

  assign start = !soft_resync && in_fire &&
                 (((state_reg == ST_SEARCHING) && s_axis_tuser) ||
                  ((state_reg == ST_TRACKING) && (eff_zero || (RESYNC_EN && s_axis_tuser))));
  assign in_frame = !soft_resync && in_fire && (start || (state_reg == ST_COLLECTING));

  // A frame-start beat is processed with the live config, later beats with the shadow copy.
  assign cur_nfft   = start ? cfg_nfft            : nfft_sh;
  assign cur_cp     = start ? cfg_cp_len          : cp_sh;
  assign cur_nsym   = start ? cfg_n_symbols       : nsym_sh;
  assign cur_gap    = start ? cfg_gap             : gap_sh;
  assign cur_lps    = start ? cfg_last_per_symbol : lps_sh;
  assign cur_sample = start ? '0                  : sample_reg;
  assign cur_sym    = start ? '0                  : sym_reg;

  assign is_payload = LW'(cur_sample) < LW'(cur_nfft);
  assign end_sym    = LW'(cur_sample) == (LW'(cur_nfft) + LW'(cur_cp) - LW'(1));
  assign end_frame  = end_sym && (cur_sym == cur_nsym);
  assign push_last  = (LW'(cur_sample) == (LW'(cur_nfft) - LW'(1))) &&
                      (cur_lps || (cur_sym == cur_nsym));
  assign push       = in_frame && is_payload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_SEARCHING;
      sample_reg      <= '0;
      sym_reg         <= '0;
      gap_reg         <= '0;
      pending_reg     <= '0;
      locked_reg      <= 1'b0;
      frame_count_reg <= '0;
      nfft_sh         <= '0;
      cp_sh           <= '0;
      nsym_sh         <= '0;
      gap_sh          <= '0;
      lps_sh          <= 1'b0;
    end else if (soft_resync) begin
      state_reg   <= ST_SEARCHING;
      sample_reg  <= '0;
      sym_reg     <= '0;
      pending_reg <= '0;
      locked_reg  <= 1'b0;
    end else begin
      if (start) begin
        nfft_sh         <= cfg_nfft;
        cp_sh           <= cfg_cp_len;
        nsym_sh         <= cfg_n_symbols;
        gap_sh          <= cfg_gap;
        lps_sh          <= cfg_last_per_symbol;
        frame_count_reg <= frame_count_reg + 16'd1;
        locked_reg      <= 1'b1;
        pending_reg     <= '0;
      end else if (state_reg == ST_TRACKING) begin
        // gap_reg is zero only when pending is positive, so nothing underflows.
        if (in_fire && gap_reg != '0) begin
          gap_reg     <= gap_reg - GAP_WIDTH'(1);
          pending_reg <= pend_sat;
        end else if (in_fire) begin
          pending_reg <= pend_sat - PEND_ONE;
        end else begin
          pending_reg <= pend_sat;
        end
      end
      if (in_frame) begin
        if (end_frame) begin
          state_reg  <= ST_TRACKING;
          gap_reg    <= cur_gap;
          sample_reg <= '0;
          sym_reg    <= '0;
        end else if (end_sym) begin
          state_reg  <= ST_COLLECTING;
          sample_reg <= '0;
          sym_reg    <= cur_sym + SCW'(1);
        end else begin
          state_reg  <= ST_COLLECTING;
          sample_reg <= cur_sample + SW'(1);
          sym_reg    <= cur_sym;
        end
      end
    end
  end

  // Payload FIFO: registered storage, head read directly so data shows one cycle after push.
  assign pop        = (count_reg != '0) && m_axis_tready;
  assign count_next = count_reg + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= {s_axis_tdata, cur_sym, push_last};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      tready_reg <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg  <= count_next;
      tready_reg <= (count_reg <= (AW+1)'(FIFO_DEPTH-2)) ||
                    ((count_reg <= (AW+1)'(FIFO_DEPTH-1)) && pop);
    end
  end

  logic [EW-1:0] head;
  assign head          = mem[rd_ptr_reg];
  assign m_axis_tvalid = (count_reg != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[EW-1 -: DW] : '0;
  assign m_axis_tuser  = m_axis_tvalid ? head[SCW:1]      : '0;
  assign m_axis_tlast  = m_axis_tvalid ? head[0]          : 1'b0;
  assign s_axis_tready = tready_reg;
  assign locked        = locked_reg;
  assign frame_count   = frame_count_reg;

endmodule

// File: tb/tb_ofdm_frame_scheduler.sv
// Directed bench for ofdm_frame_scheduler: framing, tlast modes, back-pressure, STO, resync and gap SOF.
module tb_ofdm_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] s_axis_tdata;
  logic        s_axis_tuser, s_axis_tvalid, s_axis_tready;
  logic [47:0] m_axis_tdata;
  logic [6:0]  m_axis_tuser;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [12:0] cfg_nfft;
  logic [10:0] cfg_cp_len;
  logic [6:0]  cfg_n_symbols;
  logic [19:0] cfg_gap;
  logic        cfg_last_per_symbol, soft_resync, sto_valid, sto_ready, locked;
  logic signed [7:0] sto_correction;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  int out_data[$];
  int out_user[$];
  int out_last[$];

  always #5 clk = ~clk;

  ofdm_frame_scheduler dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .cfg_nfft(cfg_nfft), .cfg_cp_len(cfg_cp_len), .cfg_n_symbols(cfg_n_symbols),
    .cfg_gap(cfg_gap), .cfg_last_per_symbol(cfg_last_per_symbol),
    .soft_resync(soft_resync), .sto_correction(sto_correction),
    .sto_valid(sto_valid), .sto_ready(sto_ready),
    .locked(locked), .frame_count(frame_count)
  );

  // Output monitor: a handshake visible at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      out_data.push_back(int'(m_axis_tdata[31:0]));
      out_user.push_back(int'(m_axis_tuser));
      out_last.push_back(int'(m_axis_tlast));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int which, input int idx);
    if (which == 0) return (idx < out_data.size()) ? out_data[idx] : -1;
    if (which == 1) return (idx < out_user.size()) ? out_user[idx] : -1;
    return (idx < out_last.size()) ? out_last[idx] : -1;
  endfunction

  task automatic clear_out();
    out_data.delete();
    out_user.delete();
    out_last.delete();
  endtask

  // Sends n consecutive beats numbered base..base+n-1; tuser set on relative indices sof_a / sof_b.
  task automatic send(input int base, input int n, input int sof_a, input int sof_b);
    int guard;
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 48'(base + i);
      s_axis_tuser  = (i == sof_a) || (i == sof_b);
      guard = 0;
      @(negedge clk);
      while (!s_axis_tready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        chk("send_timeout", 64'(guard), 64'(0));
        break;
      end
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    clear_out();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference layout for nfft=8, cp=2, two symbols: payload beats 0..7 and 10..17.
  task automatic check_two_symbol_frame(input string tag, input int lps);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_data"}, 64'(qget(0, i)), 64'((i < 8) ? i : i + 2));
      chk({tag, "_user"}, 64'(qget(1, i)), 64'((i < 8) ? 0 : 1));
      chk({tag, "_last"}, 64'(qget(2, i)), 64'((i == 15 || (lps == 1 && i == 7)) ? 1 : 0));
    end
  endtask

  initial begin
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tdata = '0;
    m_axis_tready = 1'b1;
    cfg_nfft = 13'd8; cfg_cp_len = 11'd2; cfg_n_symbols = 7'd1; cfg_gap = 20'd4;
    cfg_last_per_symbol = 1'b0; soft_resync = 1'b0;
    sto_valid = 1'b0; sto_correction = 8'sd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", 64'(s_axis_tready), 64'(0));
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_m_tuser", 64'(m_axis_tuser), 64'(0));
    chk("rst_m_tlast", 64'(m_axis_tlast), 64'(0));
    chk("rst_sto_ready", 64'(sto_ready), 64'(0));
    chk("rst_locked", 64'(locked), 64'(0));
    chk("rst_frame_count", 64'(frame_count), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("tready_before_edge", 64'(s_axis_tready), 64'(0));
    @(negedge clk);
    chk("tready_after_edge", 64'(s_axis_tready), 64'(1));

    // Basic frame: 16 payload outputs, next frame at beat 24
    @(posedge clk);
    #1;
    clear_out();
    send(0, 25, 0, -1);
    wait_cycles(4);
    chk("basic_count", 64'(out_data.size()), 64'(17));
    check_two_symbol_frame("basic", 0);
    chk("basic_next_start", 64'(qget(0, 16)), 64'(24));
    chk("basic_next_user", 64'(qget(1, 16)), 64'(0));
    chk("basic_frame_count", 64'(frame_count), 64'(2));
    chk("basic_locked", 64'(locked), 64'(1));

    // tlast per symbol
    do_reset();
    cfg_last_per_symbol = 1'b1;
    send(0, 20, 0, -1);
    wait_cycles(4);
    chk("lps_count", 64'(out_data.size()), 64'(16));
    check_two_symbol_frame("lps", 1);
    cfg_last_per_symbol = 1'b0;

    // Output stall for 40 cycles during collection
    do_reset();
    m_axis_tready = 1'b0;
    fork
      send(0, 20, 0, -1);
      begin
        repeat (35) @(negedge clk);
        chk("stall_s_tready", 64'(s_axis_tready), 64'(0));
        chk("stall_m_tvalid", 64'(m_axis_tvalid), 64'(1));
        chk("stall_head_data", 64'(m_axis_tdata), 64'(0));
        chk("stall_no_output", 64'(out_data.size()), 64'(0));
        repeat (5) @(posedge clk);
        #1 m_axis_tready = 1'b1;
      end
    join
    wait_cycles(30);
    chk("stall_count", 64'(out_data.size()), 64'(16));
    check_two_symbol_frame("stall", 0);

    // STO: gap 10, +3 while idle, then -20 with a beat -> that beat starts the frame
    do_reset();
    cfg_gap = 20'd10;
    send(0, 22, 0, -1);
    wait_cycles(2);
    chk("sto_ready_tracking", 64'(sto_ready), 64'(1));
    sto_valid = 1'b1;
    sto_correction = 8'sd3;
    @(posedge clk);
    #1 sto_valid = 1'b0;
    chk("sto_no_early_start", 64'(frame_count), 64'(1));
    sto_valid = 1'b1;
    sto_correction = -8'sd20;
    send(22, 1, -1, -1);
    sto_valid = 1'b0;
    send(23, 7, -1, -1);
    wait_cycles(4);
    chk("sto_count", 64'(out_data.size()), 64'(24));
    chk("sto_start_data", 64'(qget(0, 16)), 64'(22));
    chk("sto_start_user", 64'(qget(1, 16)), 64'(0));
    chk("sto_last_data", 64'(qget(0, 23)), 64'(29));
    chk("sto_frame_count", 64'(frame_count), 64'(2));
    chk("sto_ready_collect", 64'(sto_ready), 64'(0));

    // soft_resync mid-frame with held FIFO contents
    do_reset();
    cfg_gap = 20'd4;
    m_axis_tready = 1'b0;
    send(0, 6, 0, -1);
    chk("resync_locked_before", 64'(locked), 64'(1));
    soft_resync = 1'b1;
    @(posedge clk);
    #1 soft_resync = 1'b0;
    @(negedge clk);
    chk("resync_locked_after", 64'(locked), 64'(0));
    chk("resync_fifo_kept", 64'(m_axis_tvalid), 64'(1));
    @(posedge clk);
    #1 m_axis_tready = 1'b1;
    wait_cycles(12);
    chk("resync_drain_count", 64'(out_data.size()), 64'(6));
    chk("resync_drain_last", 64'(qget(0, 5)), 64'(5));
    send(100, 6, 2, -1);
    wait_cycles(4);
    chk("relock_count", 64'(out_data.size()), 64'(10));
    chk("relock_first", 64'(qget(0, 6)), 64'(102));
    chk("relock_user", 64'(qget(1, 6)), 64'(0));
    chk("relock_last", 64'(qget(0, 9)), 64'(105));
    chk("relock_locked", 64'(locked), 64'(1));
    chk("relock_frame_count", 64'(frame_count), 64'(2));

    // SOF at gap beat 2 of 100
    do_reset();
    cfg_gap = 20'd100;
    send(0, 121, 0, 22);
    wait_cycles(4);
`ifdef OFDM_FRAME_SCHED_RESYNC_EN
    chk("gapsof_count", 64'(out_data.size()), 64'(32));
    chk("gapsof_start", 64'(qget(0, 16)), 64'(22));
`else
    chk("gapsof_count", 64'(out_data.size()), 64'(17));
    chk("gapsof_start", 64'(qget(0, 16)), 64'(120));
`endif
    chk("gapsof_user", 64'(qget(1, 16)), 64'(0));
    chk("gapsof_frame_count", 64'(frame_count), 64'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
